ascon_perm_unit: RTL and testbench

Iterative ASCON-p permutation engine, one round per clock. It is the responder side of the round handshake driven by the ASCON-128 datapath. The datapath presents the 320-bit state (x0..x4) and a round count, then pulses start. This block runs p^a (a = 12 for initialisation/finalisation, a = 6 for data blocks), pulses done, and holds the result on its outputs until the next start.

---
 rtl/ascon_perm_unit.sv | 145 ++++++++++++++
 tb/tb_ascon_perm_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_unit.sv
// Iterative ASCON-p permutation, one round per clock.
// Ports: clk/rst, start+round_count+x*_in request; x*_out, busy, done, round_idx.
module ascon_perm_unit #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  round_count,
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out,
  output logic        busy,
  output logic        done,
  output logic [3:0]  round_idx
);

  typedef logic [4:0][63:0] st_t;
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MAXR = 4'(MAX_ROUNDS);

  state_t     state_q, state_d;
  st_t        x_q, x_in, rnd_in, rnd_out;
  logic [3:0] remaining_q;
  logic [3:0] a_eff;
  logic [3:0] rnd_idx;

  function automatic logic [63:0] ror(
    input logic [63:0] x,
    input int          r
  );
    return (x >> r) | (x << (64 - r));
  endfunction

  function automatic st_t ascon_round(
    input st_t        s,
    input logic [3:0] i
  );
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    st_t         r;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, 4'hF - i, i};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    r[2] = x2 ^ ror(x2, 1) ^ ror(x2, 6);
    r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    r[4] = x4 ^ ror(x4, 7) ^ ror(x4, 41);
    return r;
  endfunction

  assign x_in  = {x4_in, x3_in, x2_in, x1_in, x0_in};
  assign a_eff = (round_count > MAXR) ? MAXR : round_count;

  // The first round is folded into the accepting edge.
  assign rnd_in  = (state_q == IDLE) ? x_in : x_q;
  assign rnd_idx = (state_q == IDLE) ? 4'd12 - a_eff : round_idx;
  assign rnd_out = ascon_round(rnd_in, rnd_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && a_eff > 4'd1) state_d = RUN;
      RUN:  if (remaining_q == 4'd1)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      remaining_q <= '0;
      round_idx   <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (a_eff == 4'd0) begin
              x_q  <= x_in;
              done <= 1'b1;
            end else begin
              x_q         <= rnd_out;
              remaining_q <= a_eff - 4'd1;
              round_idx   <= 4'd13 - a_eff;
              done        <= (a_eff == 4'd1);
            end
          end
        end
        RUN: begin
          x_q         <= rnd_out;
          round_idx   <= round_idx + 4'd1;
          remaining_q <= remaining_q - 4'd1;
          done        <= (remaining_q == 4'd1);
        end
        default: ;
      endcase
    end
  end

  assign x0_out = x_q[0];
  assign x1_out = x_q[1];
  assign x2_out = x_q[2];
  assign x3_out = x_q[3];
  assign x4_out = x_q[4];

endmodule

// File: tb/tb_ascon_perm_unit.sv
// Directed + random bench for ascon_perm_unit.
// Reference is a column S-box table model of ASCON-p.
module tb_ascon_perm_unit;

  typedef logic [4:0][63:0] st_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  round_count = '0;
  logic [63:0] x0_in = '0, x1_in = '0, x2_in = '0, x3_in = '0, x4_in = '0;
  logic [63:0] x0_out, x1_out, x2_out, x3_out, x4_out;
  logic        busy, done;
  logic [3:0]  round_idx;

  int n_cmp = 0;
  int n_err = 0;

  localparam int SBOX [32] = '{
    'h04, 'h0b, 'h1f, 'h14, 'h1a, 'h15, 'h09, 'h02,
    'h1b, 'h05, 'h08, 'h12, 'h1d, 'h03, 'h06, 'h1c,
    'h1e, 'h13, 'h07, 'h0e, 'h00, 'h0d, 'h11, 'h18,
    'h10, 'h0c, 'h01, 'h19, 'h16, 'h0a, 'h0f, 'h17
  };
  localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
  localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

  ascon_perm_unit #(.MAX_ROUNDS(12)) dut (
    .clk(clk), .rst(rst), .start(start), .round_count(round_count),
    .x0_in(x0_in), .x1_in(x1_in), .x2_in(x2_in),
    .x3_in(x3_in), .x4_in(x4_in),
    .x0_out(x0_out), .x1_out(x1_out), .x2_out(x2_out),
    .x3_out(x3_out), .x4_out(x4_out),
    .busy(busy), .done(done), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction

  function automatic st_t ref_round(input st_t s, input int r);
    st_t        n;
    int         v;
    logic [4:0] y;
    s[2] = s[2] ^ 64'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      y = 5'(SBOX[v]);
      n[0][b] = y[4];
      n[1][b] = y[3];
      n[2][b] = y[2];
      n[3][b] = y[1];
      n[4][b] = y[0];
    end
    for (int w = 0; w < 5; w++)
      n[w] = n[w] ^ rotr(n[w], ROT1[w]) ^ rotr(n[w], ROT2[w]);
    return n;
  endfunction

  function automatic st_t ref_perm(input st_t xi, input int a);
    st_t s;
    s = xi;
    for (int r = 12 - a; r < 12; r++) s = ref_round(s, r);
    return s;
  endfunction

  function automatic st_t get_out();
    st_t o;
    o[0] = x0_out;
    o[1] = x1_out;
    o[2] = x2_out;
    o[3] = x3_out;
    o[4] = x4_out;
    return o;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic drive_in(input st_t s);
    x0_in = s[0];
    x1_in = s[1];
    x2_in = s[2];
    x3_in = s[3];
    x4_in = s[4];
  endtask

  task automatic chk(input string tag, input logic [319:0] got,
                     input logic [319:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts a job at the current negedge and returns at the negedge where
  // done is seen. inject_k re-raises start with junk while still busy.
  task automatic job(input int a, input st_t xin, input int inject_k,
                     input string tag, output st_t exp);
    int ae, lat, bcnt;
    bit seen;
    ae   = (a > 12) ? 12 : a;
    exp  = ref_perm(xin, ae);
    drive_in(xin);
    round_count = 4'(a);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_in(rand_st());
    round_count = 4'($urandom_range(0, 15));
    seen = 0;
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        seen = 1;
        lat  = k;
        break;
      end
      if (busy) begin
        bcnt++;
        chk({tag, "_idx"}, 320'(round_idx), 320'(12 - ae + k));
      end
      start = (k == inject_k);
      if (k == inject_k) drive_in(rand_st());
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_seen"}, 320'(seen), 320'(1));
    chk({tag, "_lat"}, 320'(lat), 320'((ae < 1) ? 1 : ae));
    chk({tag, "_busycnt"}, 320'(bcnt), 320'((ae < 1) ? 0 : ae - 1));
    chk({tag, "_busy_at_done"}, 320'(busy), 320'(0));
    chk({tag, "_out"}, get_out(), exp);
  endtask

  task automatic idle_chk(input string tag, input st_t exp);
    @(negedge clk);
    chk({tag, "_done_low"}, 320'(done), 320'(0));
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, get_out(), exp);
  endtask

  initial begin
    st_t  e, e2, s;
    st_t  ones;
    st_t  exp1;
    int   dseen;
    ones[0] = 64'd1;
    ones[1] = 64'd2;
    ones[2] = 64'd3;
    ones[3] = 64'd4;
    ones[4] = 64'd5;
    exp1[0] = 64'h000964B00000004B;
    exp1[1] = 64'h0000000096000213;
    exp1[2] = 64'h53FFFFFFFFFFFF90;
    exp1[3] = 64'h12E580000000004B;
    exp1[4] = 64'h0;

    repeat (2) @(negedge clk);
    chk("rst_out", get_out(), '0);
    chk("rst_flags", 320'({busy, done, round_idx}), 320'(0));
    rst = 1'b0;
    @(negedge clk);

    job(0, ones, 0, "pass", e);
    chk("pass_const", get_out(), ones);
    idle_chk("pass", e);

    job(1, '0, 0, "r1", e);
    chk("r1_const", get_out(), exp1);
    idle_chk("r1", e);

    for (int i = 0; i < 2; i++) begin
      job(12, rand_st(), 0, "p12", e);
      idle_chk("p12", e);
      job(6, rand_st(), 0, "p6", e);
      idle_chk("p6", e);
    end

    job(12, rand_st(), 4, "ign12", e);
    idle_chk("ign12", e);
    job(6, rand_st(), 2, "ign6", e);
    idle_chk("ign6", e);

    job(6, rand_st(), 0, "b2b_a", e);
    job(12, rand_st(), 0, "b2b_b", e);
    job(1, rand_st(), 0, "b2b_c", e);
    job(0, rand_st(), 0, "b2b_d", e);
    idle_chk("b2b", e);

    s = rand_st();
    job(12, s, 0, "sat12", e);
    job(15, s, 0, "sat15", e2);
    chk("sat_same", get_out(), e);
    job(13, rand_st(), 0, "sat13", e);
    idle_chk("sat", e);

    drive_in(rand_st());
    round_count = 4'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_out", get_out(), '0);
    chk("mrst_flags", 320'({busy, done, round_idx}), 320'(0));
    @(negedge clk);
    rst = 1'b0;
    dseen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    chk("mrst_nodone", 320'(dseen), 320'(0));
    job(12, rand_st(), 0, "mrst_fresh", e);
    idle_chk("mrst_fresh", e);

    for (int i = 0; i < 10; i++) begin
      job(int'($urandom_range(0, 15)), rand_st(), 0, "rnd", e);
      if ($urandom_range(0, 1) == 1) idle_chk("rnd", e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
